// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          INSTR_BYTES = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        misaligned;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory, redirect and decode-side signals of the fetch unit
interface instruction_fetch_unit_if;

   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_misaligned;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output if_valid,
      input  if_ready,
      output if_pc,
      output if_instr,
      output if_misaligned
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_pc,
      input  if_instr,
      input  if_misaligned
   );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of fetch entries; flush beats push and pop
import fetch_pkg::*;

module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t        storage [DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) storage[wr_ptr] <= push_entry;
   end

   // Empty queue presents all-zero head fields so decode never sees stale data.
   assign head = (count != '0) ? storage[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, fetch FSM and prefetch queue feeding decode
import fetch_pkg::*;

module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instruction_fetch_unit_if.master   bus
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_t  state, next_state;
   logic [63:0]   fetch_pc, next_pc;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_head;
   fetch_entry_t  push_entry;
   logic          push;
   logic          pop;
   logic          can_push;
   logic          flush;

   assign flush    = bus.redirect_valid;
   assign pop      = (q_count != '0) && bus.if_ready && !bus.redirect_valid;
   assign can_push = (state == RUN) && ((q_count < CW'(QUEUE_DEPTH)) || pop)
                     && !bus.redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= next_state;
         fetch_pc <= next_pc;
      end
   end

   always_comb begin
      next_state = state;
      next_pc    = fetch_pc;
      push       = 1'b0;
      push_entry = '0;
      if (bus.redirect_valid) begin
         next_state = RUN;
         next_pc    = bus.redirect_pc;
      end else if (can_push) begin
         push          = 1'b1;
         push_entry.pc = fetch_pc;
         if (fetch_pc[1:0] == 2'b00) begin
            push_entry.instr = bus.imem_instr;
            next_pc          = fetch_pc + 64'(INSTR_BYTES);
         end else begin
            // Misaligned target: emit one fault marker and park until redirected.
            push_entry.instr      = NOP_INSTR;
            push_entry.misaligned = 1'b1;
            next_state            = FAULT;
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .count      (q_count),
      .head       (q_head)
   );

   assign bus.imem_addr     = fetch_pc;
   assign bus.if_valid      = (q_count != '0);
   assign bus.if_pc         = q_head.pc;
   assign bus.if_instr      = q_head.instr;
   assign bus.if_misaligned = q_head.misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] mem [1024];

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC    (64'h0),
      .QUEUE_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.imem_instr = mem[bus.imem_addr[11:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                           input logic mis);
      chk({tag, "_valid"}, 64'(bus.if_valid), 64'd1);
      chk({tag, "_pc"}, bus.if_pc, pc);
      chk({tag, "_instr"}, 64'(bus.if_instr), 64'(instr));
      chk({tag, "_mis"}, 64'(bus.if_misaligned), 64'(mis));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_1000 + 32'(i);
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      rst_n              = 1'b0;
      bus.if_ready       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h500;
      #2;
      chk("rst_valid", 64'(bus.if_valid), 64'd0);
      chk("rst_pc", bus.if_pc, 64'd0);
      chk("rst_instr", 64'(bus.if_instr), 64'd0);
      chk("rst_mis", 64'(bus.if_misaligned), 64'd0);
      chk("rst_addr", bus.imem_addr, 64'd0);
      step();
      chk("rst_redirect_ignored", bus.imem_addr, 64'd0);
      bus.redirect_valid = 1'b0;
      rst_n = 1'b1;
      chk("c0_valid", 64'(bus.if_valid), 64'd0);
      step();
      chk_head("c1", 64'h0, 32'h11, 1'b0);
      step();
      chk_head("c2", 64'h4, 32'h22, 1'b0);
      step();
      chk_head("c3", 64'h8, 32'h33, 1'b0);

      // Backpressure: queue fills with 8,C and fetch parks at 0x10
      bus.if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_pc", bus.if_pc, 64'h8);
         chk("stall_addr", bus.imem_addr, 64'h10);
      end
      bus.if_ready = 1'b1;
      step();
      chk_head("rel_c", 64'hC, 32'h1003, 1'b0);
      step();
      chk_head("rel_10", 64'h10, 32'h1004, 1'b0);

      // Redirect with a full, stalled queue holding 0x10,0x14
      bus.if_ready = 1'b0;
      step();
      chk("full_pc", bus.if_pc, 64'h10);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h40;
      step();
      bus.redirect_valid = 1'b0;
      bus.if_ready       = 1'b1;
      chk("redir_valid0", 64'(bus.if_valid), 64'd0);
      chk("redir_addr", bus.imem_addr, 64'h40);
      step();
      chk_head("redir_40", 64'h40, 32'h1010, 1'b0);
      step();
      chk_head("seq_44", 64'h44, 32'h1011, 1'b0);

      // Redirect coincident with a valid, ready head, to a misaligned target
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h42;
      step();
      bus.redirect_valid = 1'b0;
      chk("mis_valid0", 64'(bus.if_valid), 64'd0);
      chk("mis_addr", bus.imem_addr, 64'h42);
      step();
      chk_head("mis_head", 64'h42, 32'h13, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fault_idle_valid", 64'(bus.if_valid), 64'd0);
         chk("fault_addr", bus.imem_addr, 64'h42);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h100;
      step();
      bus.redirect_valid = 1'b0;
      chk("res_valid0", 64'(bus.if_valid), 64'd0);
      step();
      chk_head("res_100", 64'h100, 32'h1040, 1'b0);
      step();
      chk_head("res_104", 64'h104, 32'h1041, 1'b0);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.if_valid), 64'd0);
      chk("arst_addr", bus.imem_addr, 64'd0);
      chk("arst_pc", bus.if_pc, 64'd0);
      step();
      rst_n = 1'b1;
      chk("r0_valid", 64'(bus.if_valid), 64'd0);
      step();
      chk_head("r1", 64'h0, 32'h11, 1'b0);
      step();
      chk_head("r2", 64'h4, 32'h22, 1'b0);

      // PC wrap at the top of the address space
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      chk("wrap_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk_head("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 32'h13FF, 1'b0);
      step();
      chk_head("wrap_zero", 64'h0, 32'h11, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
